// File: rtl/soc_timer_if.sv
// Slave-side bus bundle for the timer: address, write data, read data and the
// per-slave write/read strobes produced by the system bus decoder.
interface soc_timer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;
  logic              we_i;
  logic              rd_i;

  modport master (
    output addr_i,
    output data_i,
    output we_i,
    output rd_i,
    input  data_o
  );

  modport slave (
    input  addr_i,
    input  data_i,
    input  we_i,
    input  rd_i,
    output data_o
  );
endinterface

// File: rtl/soc_timer.sv
// Memory-mapped timer: prescaler, up-counter with programmable period,
// one-shot or periodic mode, sticky W1C expiry flag and level interrupt.
module soc_timer #(
  parameter int PRESCALE = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  soc_timer_if.slave     bus,
  output logic           irq_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [2:0]        ctrl_reg;
  logic [DATA_W-1:0] period_reg;
  logic [DATA_W-1:0] count_reg;
  logic              expired_reg;
  logic [PW-1:0]     pre_reg;

  logic [1:0] sel;
  logic       wr_ctrl;
  logic       wr_period;
  logic       wr_count;
  logic       wr_status;
  logic       tick;
  logic       expire;
  logic       unused_addr;

  assign sel         = bus.addr_i[3:2];
  assign unused_addr = ^{bus.addr_i[ADDR_W-1:4], bus.addr_i[1:0]};

  assign wr_ctrl   = bus.we_i && (sel == 2'd0);
  assign wr_period = bus.we_i && (sel == 2'd1);
  assign wr_count  = bus.we_i && (sel == 2'd2);
  assign wr_status = bus.we_i && (sel == 2'd3);

  generate
    if (PRESCALE == 1) begin : g_no_prescale
      assign tick = ctrl_reg[0];
    end else begin : g_prescale
      assign tick = ctrl_reg[0] && (pre_reg == PW'(PRESCALE - 1));
    end
  endgenerate

  // Compare is >= so a PERIOD written below the running COUNT expires on the next tick.
  assign expire = tick && (count_reg >= period_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg    <= '0;
      period_reg  <= '0;
      count_reg   <= '0;
      expired_reg <= 1'b0;
      pre_reg     <= '0;
    end else begin
      if (wr_ctrl || wr_count || !ctrl_reg[0] || tick) begin
        pre_reg <= '0;
      end else begin
        pre_reg <= pre_reg + PW'(1);
      end

      // Bus writes take priority over the tick update and the one-shot auto-disable.
      if (wr_ctrl) begin
        ctrl_reg <= bus.data_i[2:0];
      end else if (expire && !ctrl_reg[1]) begin
        ctrl_reg[0] <= 1'b0;
      end

      if (wr_period) begin
        period_reg <= bus.data_i;
      end

      if (wr_count) begin
        count_reg <= bus.data_i;
      end else if (expire) begin
        count_reg <= '0;
      end else if (tick) begin
        count_reg <= count_reg + DATA_W'(1);
      end

      if (expire) begin
        expired_reg <= 1'b1;
      end else if (wr_status && bus.data_i[0]) begin
        expired_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.data_o = '0;
    if (bus.rd_i) begin
      case (sel)
        2'd0:    bus.data_o = {{(DATA_W-3){1'b0}}, ctrl_reg};
        2'd1:    bus.data_o = period_reg;
        2'd2:    bus.data_o = count_reg;
        default: bus.data_o = {{(DATA_W-1){1'b0}}, expired_reg};
      endcase
    end
  end

  assign irq_o = expired_reg && ctrl_reg[2];

endmodule

// File: tb/tb_soc_timer.sv
// Drives identical bus traffic into a PRESCALE=1 and a PRESCALE=4 timer and
// compares both against a behavioural model of the register-level rules.
module tb_soc_timer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  soc_timer_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  soc_timer_if #(.ADDR_W(32), .DATA_W(32)) bus4 ();
  logic irq1;
  logic irq4;

  soc_timer #(.PRESCALE(1), .ADDR_W(32), .DATA_W(32)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave),
    .irq_o (irq1)
  );

  soc_timer #(.PRESCALE(4), .ADDR_W(32), .DATA_W(32)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave),
    .irq_o (irq4)
  );

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] period;
    logic [31:0] count;
    logic        expired;
    int          pre;
  } tstate_t;

  tstate_t     ms [2];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rdat [2];
  logic        irqs [2];

  localparam logic [31:0] A_CTRL   = 32'h2000_0000;
  localparam logic [31:0] A_PERIOD = 32'h2000_0004;
  localparam logic [31:0] A_COUNT  = 32'h2000_0008;
  localparam logic [31:0] A_STATUS = 32'h2000_000C;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pres_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic tstate_t zero_state();
    tstate_t s;
    s.ctrl = 3'd0; s.period = 32'd0; s.count = 32'd0; s.expired = 1'b0; s.pre = 0;
    return s;
  endfunction

  function automatic logic [31:0] model_rd(input tstate_t s, input logic rd, input logic [1:0] sel);
    if (!rd)       return 32'd0;
    if (sel == 0)  return {29'd0, s.ctrl};
    if (sel == 1)  return s.period;
    if (sel == 2)  return s.count;
    return {31'd0, s.expired};
  endfunction

  function automatic logic model_irq(input tstate_t s);
    return s.expired & s.ctrl[2];
  endfunction

  // One clock edge of the timer rules: tick first, then bus writes override.
  function automatic tstate_t model_next(input tstate_t s, input int p, input logic we,
                                         input logic [1:0] sel, input logic [31:0] d);
    tstate_t n;
    bit en, tick, exp_now;
    n       = s;
    en      = s.ctrl[0];
    tick    = en && (s.pre == p - 1);
    exp_now = tick && (s.count >= s.period);
    n.pre   = en ? (s.pre + 1) % p : 0;
    if (tick) begin
      if (exp_now) begin
        n.count   = 32'd0;
        n.expired = 1'b1;
        if (!s.ctrl[1]) n.ctrl[0] = 1'b0;
      end else begin
        n.count = s.count + 32'd1;
      end
    end
    if (we) begin
      if (sel == 0) begin n.ctrl = d[2:0]; n.pre = 0; end
      if (sel == 1) n.period = d;
      if (sel == 2) begin n.count = d; n.pre = 0; end
      if (sel == 3 && d[0] && !exp_now) n.expired = 1'b0;
    end
    return n;
  endfunction

  task automatic drive(input logic we, input logic rd, input logic [31:0] a, input logic [31:0] d);
    bus1.we_i = we; bus1.rd_i = rd; bus1.addr_i = a; bus1.data_i = d;
    bus4.we_i = we; bus4.rd_i = rd; bus4.addr_i = a; bus4.data_i = d;
  endtask

  task automatic cyc(input logic we, input logic rd, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(we, rd, a, d);
    #1;
    rdat[0] = bus1.data_o; rdat[1] = bus4.data_o;
    irqs[0] = irq1;        irqs[1] = irq4;
    check_eq("rdata_p1", rdat[0], model_rd(ms[0], rd, a[3:2]));
    check_eq("irq_p1",   {31'd0, irqs[0]}, {31'd0, model_irq(ms[0])});
    check_eq("rdata_p4", rdat[1], model_rd(ms[1], rd, a[3:2]));
    check_eq("irq_p4",   {31'd0, irqs[1]}, {31'd0, model_irq(ms[1])});
    $display("[TB] t=%0t we=%0b rd=%0b addr=%08h wdata=%08h rd_p1=%08h rd_p4=%08h irq=%0b%0b",
             $time, we, rd, a, d, rdat[0], rdat[1], irqs[0], irqs[1]);
    @(posedge clk);
    for (int i = 0; i < 2; i++) ms[i] = model_next(ms[i], pres_of(i), we, a[3:2], d);
  endtask

  task automatic clean();
    cyc(1'b1, 1'b0, A_CTRL, 32'd0);
    cyc(1'b1, 1'b0, A_COUNT, 32'd0);
    cyc(1'b1, 1'b0, A_STATUS, 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic        rd;
    ms[0] = zero_state();
    ms[1] = zero_state();
    drive(1'b0, 1'b1, A_CTRL, 32'd0);

    // Reset state: every offset reads zero
    repeat (3) @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      bus1.addr_i = A_CTRL + 32'(4 * k); bus4.addr_i = A_CTRL + 32'(4 * k);
      #1;
      check_eq("reset_rd_p1", bus1.data_o, 32'd0);
      check_eq("reset_rd_p4", bus4.data_o, 32'd0);
    end
    check_eq("reset_irq", {30'd0, irq1, irq4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Readback
    cyc(1'b1, 1'b0, A_PERIOD, 32'h1234_5678);
    cyc(1'b0, 1'b1, A_PERIOD, 32'd0);
    check_eq("period_readback", rdat[0], 32'h1234_5678);
    cyc(1'b1, 1'b0, A_CTRL, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b1, A_CTRL, 32'd0);
    check_eq("ctrl_readback", rdat[0], 32'h0000_0007);

    // Periodic, PRESCALE=1, PERIOD=3
    clean();
    cyc(1'b1, 1'b0, A_PERIOD, 32'd3);
    cyc(1'b1, 1'b0, A_CTRL, 32'h7);
    cyc(1'b0, 1'b1, A_COUNT, 32'd0);
    cyc(1'b0, 1'b1, A_COUNT, 32'd0); check_eq("periodic_c1", rdat[0], 32'd1);
    cyc(1'b0, 1'b1, A_COUNT, 32'd0); check_eq("periodic_c2", rdat[0], 32'd2);
    cyc(1'b0, 1'b1, A_COUNT, 32'd0); check_eq("periodic_c3", rdat[0], 32'd3);
    check_eq("periodic_irq_low", {31'd0, irqs[0]}, 32'd0);
    cyc(1'b0, 1'b1, A_COUNT, 32'd0); check_eq("periodic_c0", rdat[0], 32'd0);
    check_eq("periodic_irq_high", {31'd0, irqs[0]}, 32'd1);
    // W1C lands on the next expiry edge: set wins
    cyc(1'b0, 1'b1, A_STATUS, 32'd0);
    cyc(1'b0, 1'b1, A_STATUS, 32'd0);
    cyc(1'b1, 1'b1, A_STATUS, 32'd1);
    check_eq("w1c_prewrite_rd", rdat[0], 32'd1);
    cyc(1'b0, 1'b1, A_STATUS, 32'd0); check_eq("w1c_vs_expiry", rdat[0], 32'd1);
    cyc(1'b1, 1'b0, A_STATUS, 32'd1);
    cyc(1'b0, 1'b1, A_STATUS, 32'd0); check_eq("w1c_irq_drop", {31'd0, irqs[0]}, 32'd0);
    // COUNT write on a tick edge wins, then expires on the next tick
    cyc(1'b1, 1'b0, A_COUNT, 32'h10);
    cyc(1'b0, 1'b1, A_COUNT, 32'd0); check_eq("count_write_wins", rdat[0], 32'h10);
    cyc(1'b0, 1'b1, A_COUNT, 32'd0); check_eq("count_over_period", rdat[0], 32'd0);

    // Pause at COUNT=2 and resume
    clean();
    cyc(1'b1, 1'b0, A_CTRL, 32'h7);
    cyc(1'b0, 1'b1, A_COUNT, 32'd0);
    cyc(1'b1, 1'b0, A_CTRL, 32'h6);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b1, A_COUNT, 32'd0);
      check_eq("pause_hold", rdat[0], 32'd2);
    end
    cyc(1'b1, 1'b0, A_CTRL, 32'h7);
    cyc(1'b0, 1'b1, A_COUNT, 32'd0);
    cyc(1'b0, 1'b1, A_COUNT, 32'd0); check_eq("resume_c3", rdat[0], 32'd3);
    cyc(1'b0, 1'b1, A_COUNT, 32'd0); check_eq("resume_c0", rdat[0], 32'd0);

    // PERIOD=0 expires on every tick
    cyc(1'b1, 1'b0, A_PERIOD, 32'd0);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, A_STATUS, 32'd1);
      cyc(1'b0, 1'b1, A_STATUS, 32'd0);
    end

    // One-shot, PRESCALE=4, PERIOD=2
    clean();
    cyc(1'b1, 1'b0, A_PERIOD, 32'd2);
    cyc(1'b1, 1'b0, A_CTRL, 32'h5);
    for (int k = 1; k <= 13; k++) begin
      cyc(1'b0, 1'b1, A_STATUS, 32'd0);
      if (k == 12) check_eq("oneshot_not_yet", rdat[1], 32'd0);
    end
    check_eq("oneshot_expired", rdat[1], 32'd1);
    check_eq("oneshot_irq", {31'd0, irqs[1]}, 32'd1);
    cyc(1'b0, 1'b1, A_CTRL, 32'd0);  check_eq("oneshot_ctrl", rdat[1], 32'h4);
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, A_COUNT, 32'd0);
    check_eq("oneshot_count_hold", rdat[1], 32'd0);
    check_eq("oneshot_irq_hold", {31'd0, irqs[1]}, 32'd1);
    cyc(1'b1, 1'b0, A_STATUS, 32'd1);
    cyc(1'b0, 1'b1, A_STATUS, 32'd0); check_eq("oneshot_irq_cleared", {31'd0, irqs[1]}, 32'd0);

    // Top of range: COUNT reaches all-ones, then expires to 0
    clean();
    cyc(1'b1, 1'b0, A_PERIOD, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b0, A_COUNT, 32'hFFFF_FFFE);
    cyc(1'b1, 1'b0, A_CTRL, 32'h3);
    cyc(1'b0, 1'b1, A_COUNT, 32'd0);
    cyc(1'b0, 1'b1, A_COUNT, 32'd0); check_eq("top_count_max", rdat[0], 32'hFFFF_FFFF);
    cyc(1'b0, 1'b1, A_COUNT, 32'd0); check_eq("top_count_wrap", rdat[0], 32'd0);
    for (int k = 0; k < 12; k++) cyc(1'b0, 1'b1, A_COUNT, 32'd0);

    // Randomized traffic against the model
    clean();
    for (int k = 0; k < 1500; k++) begin
      a  = $urandom();
      we = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 7) != 0);
      case (a[3:2])
        2'd0:    d = $urandom();
        2'd1:    d = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 9));
        2'd2:    d = 32'($urandom_range(0, 12));
        default: d = $urandom();
      endcase
      cyc(we, rd, a, d);
    end

    // Asynchronous reset mid-run with COUNT=5 and irq high
    clean();
    cyc(1'b1, 1'b0, A_PERIOD, 32'd9);
    cyc(1'b1, 1'b0, A_CTRL, 32'h7);
    for (int k = 0; k < 15; k++) cyc(1'b0, 1'b1, A_COUNT, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, A_COUNT, 32'd0);
    #1;
    check_eq("prereset_count", bus1.data_o, 32'd5);
    check_eq("prereset_irq", {31'd0, irq1}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_count_p1", bus1.data_o, 32'd0);
    check_eq("async_rst_count_p4", bus4.data_o, 32'd0);
    check_eq("async_rst_irq", {30'd0, irq1, irq4}, 32'd0);
    drive(1'b0, 1'b1, A_CTRL, 32'd0);
    #1;
    check_eq("async_rst_ctrl", bus1.data_o | bus4.data_o, 32'd0);
    ms[0] = zero_state();
    ms[1] = zero_state();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, A_CTRL + 32'(4 * k), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
